// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text formatting path.
// Holds HD44780 command bytes, the ASCII codes the formatter reacts to,
// the bus item type handed to the LCD bus driver, the formatter state
// encoding, and small helpers used when decoding characters.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] ROW1_BASE     = 8'h40;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_FF      = 8'h0C;
  localparam logic [7:0] ASCII_MIN     = 8'h20;
  localparam logic [7:0] ASCII_MAX     = 8'h7E;

  // One write to the LCD: rs=1 character data, rs=0 command.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_item_t;

  typedef enum logic [1:0] {
    S_CLR  = 2'd0,
    S_IDLE = 2'd1,
    S_ADDR = 2'd2,
    S_EMIT = 2'd3
  } fmt_state_t;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= ASCII_MIN) && (ch <= ASCII_MAX);
  endfunction

  // Set-DDRAM-address command pointing at column 0 of the given row.
  function automatic logic [7:0] set_addr_cmd(input logic row);
    return CMD_SET_DDRAM | (row ? ROW1_BASE : 8'h00);
  endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Synchronous single-clock character FIFO.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   push, push_data : write request and byte (ignored when full)
//   pop             : read request (ignored when empty)
//   head            : byte at the head of the queue (valid when !empty)
//   count           : current occupancy, 0..DEPTH
//   empty           : occupancy is zero
module lcd_char_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push && (count_r != DEPTH_C);
  assign pop_s  = pop && (count_r != CNT_W'(0));

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CNT_W'(0));

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_formatter.sv
// Character stream to HD44780 bus item formatter.
// Buffers ASCII input in a FIFO, tracks the cursor on a ROWS x COLS display
// and emits an ordered stream of {rs, byte} items: characters (rs=1) plus
// clear and set-DDRAM-address commands (rs=0) for wrap, LF and FF.
// Ports:
//   clk, reset                    : rising-edge clock, synchronous active-high reset
//   in_valid, in_ready, in_char   : character input handshake
//   out_valid, out_ready          : bus item handshake toward the driver
//   out_rs, out_data              : bus item, stable while stalled
//   fifo_count                    : current FIFO occupancy
module lcd_text_formatter
  import lcd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int COLS  = 16,
  parameter int ROWS  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_char,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_rs,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int COL_W = $clog2(COLS + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [COL_W-1:0] COLS_C  = COL_W'(COLS);

  fmt_state_t       state_r;
  lcd_item_t        item_r;
  logic             out_valid_r;
  logic             row_r;
  logic [COL_W-1:0] col_r;
  logic [7:0]       held_r;

  logic [7:0]       head_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic             push_s;
  logic             pop_s;
  logic             xfer_s;
  logic             row_next_s;

  fmt_state_t       dec_state_s;
  lcd_item_t        dec_item_s;
  logic             dec_valid_s;
  logic             dec_row_s;
  logic [COL_W-1:0] dec_col_s;
  logic [7:0]       dec_held_s;

  lcd_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (in_char),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s)
  );

  // in_ready comes from the registered count only, so a pop never raises it early.
  assign in_ready   = (count_s < DEPTH_C);
  assign push_s     = in_valid && in_ready;
  assign xfer_s     = out_valid_r && out_ready;
  assign row_next_s = (ROWS == 2) ? ~row_r : 1'b0;

  assign out_valid  = out_valid_r;
  assign out_rs     = item_r.rs;
  assign out_data   = item_r.data;
  assign fifo_count = count_s;

  // Pop when idle, or when the current item leaves and the next byte can replace it on the same edge.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      S_IDLE:  pop_s = !empty_s;
      S_EMIT:  pop_s = xfer_s && !empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Decode the FIFO head against the cursor into the next item, cursor and state.
  always_comb begin
    dec_item_s  = '{rs: 1'b0, data: 8'h00};
    dec_valid_s = 1'b0;
    dec_state_s = S_IDLE;
    dec_row_s   = row_r;
    dec_col_s   = col_r;
    dec_held_s  = held_r;
    if (is_printable(head_s)) begin
      if (col_r < COLS_C) begin
        dec_item_s  = '{rs: 1'b1, data: head_s};
        dec_valid_s = 1'b1;
        dec_col_s   = col_r + COL_W'(1);
        dec_state_s = S_EMIT;
      end else begin
        // Deferred wrap: move the cursor first, the character follows from S_ADDR.
        dec_item_s  = '{rs: 1'b0, data: set_addr_cmd(row_next_s)};
        dec_valid_s = 1'b1;
        dec_row_s   = row_next_s;
        dec_col_s   = COL_W'(0);
        dec_held_s  = head_s;
        dec_state_s = S_ADDR;
      end
    end else if (head_s == ASCII_LF) begin
      dec_item_s  = '{rs: 1'b0, data: set_addr_cmd(row_next_s)};
      dec_valid_s = 1'b1;
      dec_row_s   = row_next_s;
      dec_col_s   = COL_W'(0);
      dec_state_s = S_EMIT;
    end else if (head_s == ASCII_FF) begin
      dec_item_s  = '{rs: 1'b0, data: CMD_CLEAR};
      dec_valid_s = 1'b1;
      dec_row_s   = 1'b0;
      dec_col_s   = COL_W'(0);
      dec_state_s = S_EMIT;
    end else begin
      // Unsupported control byte: consumed silently.
      dec_valid_s = 1'b0;
      dec_state_s = S_IDLE;
    end
  end

  // Formatter FSM with registered bus item and cursor.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_CLR;
      out_valid_r <= 1'b0;
      item_r      <= '{rs: 1'b0, data: 8'h00};
      row_r       <= 1'b0;
      col_r       <= COL_W'(0);
      held_r      <= 8'h00;
    end else begin
      case (state_r)
        S_CLR: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            item_r      <= '{rs: 1'b0, data: CMD_CLEAR};
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            row_r       <= 1'b0;
            col_r       <= COL_W'(0);
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_CLR;
          end
        end
        S_IDLE, S_EMIT: begin
          if (pop_s) begin
            state_r     <= dec_state_s;
            out_valid_r <= dec_valid_s;
            item_r      <= dec_item_s;
            row_r       <= dec_row_s;
            col_r       <= dec_col_s;
            held_r      <= dec_held_s;
          end else if (xfer_s) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        S_ADDR: begin
          if (xfer_s) begin
            item_r  <= '{rs: 1'b1, data: held_r};
            col_r   <= COL_W'(1);
            state_r <= S_EMIT;
          end else begin
            state_r <= S_ADDR;
          end
        end
        default: begin
          state_r     <= S_CLR;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Self-checking bench for lcd_text_formatter with a cursor-level model of
// the expected bus item stream and directed literal checks.
module tb_lcd_text_formatter;

  localparam int DEPTH = 16;
  localparam int COLS  = 16;
  localparam int ROWS  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_rs;
  logic [7:0] out_data;
  logic [4:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int m_row = 0;
  int m_col = 0;
  logic [8:0] exp_q [$];
  logic [8:0] log_q [$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_item = 9'h000;

  always #5 clk = ~clk;

  lcd_text_formatter #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs     (out_rs),
    .out_data   (out_data),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Display-level model: what the LCD must be told for one accepted character.
  function automatic void model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      if (m_col == COLS) begin
        m_row = (m_row + 1) % ROWS;
        m_col = 0;
        exp_q.push_back({1'b0, (m_row == 1) ? 8'hC0 : 8'h80});
      end
      exp_q.push_back({1'b1, c});
      m_col++;
    end else if (c == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
      m_col = 0;
      exp_q.push_back({1'b0, (m_row == 1) ? 8'hC0 : 8'h80});
    end else if (c == 8'h0C) begin
      exp_q.push_back(9'h001);
      m_row = 0;
      m_col = 0;
    end
  endfunction

  // Compare process: sampled on the falling edge, describing the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_q.push_back(9'h001);
      m_row = 0;
      m_col = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_item", {23'd0, out_rs, out_data}, {23'd0, prev_item});
      end
      if (out_valid && out_ready) begin
        log_q.push_back({out_rs, out_data});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_item: got %0h expected none", {out_rs, out_data});
        end else begin
          check("item", {23'd0, out_rs, out_data}, {23'd0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_item  = {out_rs, out_data};
      if (in_valid && in_ready) begin
        acc_cnt++;
        model_char(in_char);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !out_valid && fifo_count == 5'd0) && n < 200) begin
      tick();
      n++;
    end
    check(name, {31'd0, (n < 200)}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int a0;

    // Test 1: reset state, then clear command held while stalled.
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'h00);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("clr_valid", {31'd0, out_valid}, 32'd1);
      check("clr_item", {23'd0, out_rs, out_data}, 32'h001);
    end
    out_ready = 1'b1;
    tick();
    check("clr_done", {31'd0, out_valid}, 32'd0);

    // Test 2: "Hello" with latency and order.
    base = log_q.size();
    in_valid = 1'b1;
    in_char  = 8'h48;
    tick();
    check("lat_edge1", {31'd0, out_valid}, 32'd0);
    in_char = 8'h65;
    tick();
    check("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_edge2_item", {23'd0, out_rs, out_data}, 32'h148);
    in_char = 8'h6C;
    tick();
    in_char = 8'h6C;
    tick();
    in_char = 8'h6F;
    tick();
    in_valid = 1'b0;
    drain("hello_drain");
    check("hello_n", log_q.size() - base, 32'd5);
    check("hello_0", {23'd0, log_q[base]}, 32'h148);
    check("hello_4", {23'd0, log_q[base+4]}, 32'h16F);
    check("hello_count", {27'd0, fifo_count}, 32'd0);

    // Test 3: FF then 18 'A' -> deferred wrap to row 1.
    base = log_q.size();
    push_one(8'h0C);
    in_valid = 1'b1;
    in_char  = 8'h41;
    for (int i = 0; i < 18; i++) tick();
    in_valid = 1'b0;
    drain("wrap_drain");
    check("wrap_n", log_q.size() - base, 32'd20);
    check("wrap_ff", {23'd0, log_q[base]}, 32'h001);
    check("wrap_16", {23'd0, log_q[base+16]}, 32'h141);
    check("wrap_addr", {23'd0, log_q[base+17]}, 32'h0C0);
    check("wrap_17", {23'd0, log_q[base+18]}, 32'h141);
    check("wrap_18", {23'd0, log_q[base+19]}, 32'h141);

    // Test 4: LF at row 1, FF, and a discarded control byte.
    base = log_q.size();
    push_one(8'h0A);
    push_one(8'h0C);
    drain("ctl_drain");
    check("lf_addr", {23'd0, log_q[base]}, 32'h080);
    check("ff_clear", {23'd0, log_q[base+1]}, 32'h001);
    base = log_q.size();
    push_one(8'h07);
    check("bel_count1", {27'd0, fifo_count}, 32'd1);
    tick();
    check("bel_count0", {27'd0, fifo_count}, 32'd0);
    check("bel_novalid", {31'd0, out_valid}, 32'd0);
    check("bel_nolog", log_q.size() - base, 32'd0);

    // Test 5: backpressure fills the FIFO with the output register already busy.
    base = log_q.size();
    out_ready = 1'b0;
    push_one(8'h5A);
    tick();
    check("bp_pending", {23'd0, out_rs, out_data}, 32'h15A);
    a0 = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_char  = 8'(8'h61 + i);
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", acc_cnt - a0, 32'd16);
    check("bp_count", {27'd0, fifo_count}, 32'd16);
    check("bp_in_ready0", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    check("bp_in_ready_pre", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp_in_ready1", {31'd0, in_ready}, 32'd1);
    check("bp_count15", {27'd0, fifo_count}, 32'd15);
    drain("bp_drain");
    check("bp_n", log_q.size() - base, 32'd18);
    check("bp_a", {23'd0, log_q[base+1]}, 32'h161);
    check("bp_addr", {23'd0, log_q[base+16]}, 32'h0C0);
    check("bp_p", {23'd0, log_q[base+17]}, 32'h170);

    // Test 6: reset mid-stream drops FIFO contents and the pending item.
    out_ready = 1'b0;
    push_one(8'h51);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_char = 8'(8'h30 + i);
      tick();
    end
    in_valid = 1'b0;
    check("mid_count8", {27'd0, fifo_count}, 32'd8);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    base = log_q.size();
    reset = 1'b1;
    tick();
    check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check("mid_clr_item", {23'd0, out_rs, out_data}, 32'h001);
    check("mid_clr_valid", {31'd0, out_valid}, 32'd1);
    drain("mid_drain");
    repeat (4) tick();
    check("mid_n", log_q.size() - base, 32'd1);
    check("mid_first", {23'd0, log_q[base]}, 32'h001);
    check("exp_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
